// File: rtl/usb_linestate_filter_pkg.sv
// Shared encodings for the USB linestate front end: bus linestates and
// the bus-reset detector states that the register readout also decodes.
package usb_linestate_filter_pkg;

    typedef enum logic [1:0] {
        USB_LS_SE0  = 2'b00,
        USB_LS_J_FS = 2'b01,
        USB_LS_K_FS = 2'b10,
        USB_LS_SE1  = 2'b11
    } usb_ls_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_SE0_TIME  = 2'b10,
        ST_BUS_RESET = 2'b11
    } fe_state_e;

    localparam logic [7:0] RESET_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/usb_linestate_filter_debounce.sv
// Synchroniser plus debounce for the raw 2-bit PHY linestate; emits a clean
// linestate and a one-cycle change strobe registered with it.
module usb_linestate_debounce #(
    parameter int pSYNC_STAGES = 2,
    parameter int pDEBOUNCE    = 4
) (
    input  logic       fe_clk,
    input  logic       resetn,
    input  logic [1:0] raw_ls,
    output logic [1:0] linestate,
    output logic       changed
);

    localparam int                DCNT_W   = $clog2(pDEBOUNCE + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(pDEBOUNCE);

    if (pSYNC_STAGES < 2) begin : g_bad_sync
        $error("pSYNC_STAGES must be 2 or more");
    end
    if (pDEBOUNCE < 1) begin : g_bad_debounce
        $error("pDEBOUNCE must be 1 or more");
    end

    logic [pSYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0]                   cand_q, cand_d;
    logic [DCNT_W-1:0]            dcnt_q, dcnt_d;
    logic [1:0]                   ls_q, ls_d;
    logic                         changed_q, changed_d;
    logic [1:0]                   s;

    assign s = sync_q[pSYNC_STAGES-1];

    always_comb begin
        // NOTE: every _d gets a default first so no path can leave it unassigned and infer a latch.
        sync_d    = {sync_q[pSYNC_STAGES-2:0], raw_ls};
        cand_d    = cand_q;
        dcnt_d    = dcnt_q;
        ls_d      = ls_q;
        changed_d = 1'b0;

        if (s != cand_q) begin
            cand_d = s;
            dcnt_d = DCNT_W'(1);
        end else if (dcnt_q != DCNT_MAX) begin
            dcnt_d = dcnt_q + 1'b1;
        end

        // Acceptance looks at the registered candidate, so a run is judged once it is complete.
        if (dcnt_q == DCNT_MAX && cand_q != ls_q) begin
            ls_d      = cand_q;
            changed_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fe_clk) begin
        if (!resetn) begin
            // NOTE: the synchroniser is a handful of flops, not a memory, so it is reset like the rest.
            sync_q    <= '0;
            cand_q    <= 2'b00;
            dcnt_q    <= '0;
            ls_q      <= 2'b00;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cand_q    <= cand_d;
            dcnt_q    <= dcnt_d;
            ls_q      <= ls_d;
            changed_q <= changed_d;
        end
    end

    assign linestate = ls_q;
    assign changed   = changed_q;

endmodule

// File: rtl/usb_linestate_filter.sv
// Front-end linestate filter: debounced linestate, SE0 bus-reset timing,
// end-of-reset restart pulse and a saturating bus-reset counter.
module usb_linestate_filter #(
    parameter int pSYNC_STAGES   = 2,
    parameter int pDEBOUNCE      = 4,
    parameter int pSE0_RESET     = 1024,
    parameter int pCOUNTER_WIDTH = 21
) (
    input  logic       fe_clk,
    input  logic       resetn,
    input  logic       fe_linestate0,
    input  logic       fe_linestate1,
    input  logic       I_enable,
    output logic [1:0] O_linestate,
    output logic       O_changed,
    output logic       O_bus_reset,
    output logic       O_restart,
    output logic [7:0] O_reset_count
);

    import usb_linestate_filter_pkg::*;

    if (longint'(pSE0_RESET) > (longint'(1) << pCOUNTER_WIDTH) - 1) begin : g_bad_width
        $error("pSE0_RESET does not fit in pCOUNTER_WIDTH bits");
    end

    localparam logic [pCOUNTER_WIDTH-1:0] SE0_LAST = pCOUNTER_WIDTH'(pSE0_RESET - 1);

    logic [1:0] ls;

    usb_linestate_debounce #(
        .pSYNC_STAGES(pSYNC_STAGES),
        .pDEBOUNCE   (pDEBOUNCE)
    ) u_debounce (
        .fe_clk   (fe_clk),
        .resetn   (resetn),
        .raw_ls   ({fe_linestate1, fe_linestate0}),
        .linestate(ls),
        .changed  (O_changed)
    );

    fe_state_e                 state_q, state_d;
    logic [pCOUNTER_WIDTH-1:0] timer_q, timer_d;
    logic                      bus_reset_q, bus_reset_d;
    logic                      restart_q, restart_d;
    logic [7:0]                count_q, count_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bus_reset_d = bus_reset_q;
        restart_d   = 1'b0;
        count_d     = count_q;

        if (!I_enable) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            bus_reset_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (ls == USB_LS_SE0) begin
                        timer_d = pCOUNTER_WIDTH'(1);
                        state_d = ST_SE0_TIME;
                    end
                end
                ST_SE0_TIME: begin
                    if (ls != USB_LS_SE0) begin
                        timer_d = '0;
                        state_d = ST_RUN;
                    end else if (timer_q >= SE0_LAST) begin
                        // >= rather than == keeps pSE0_RESET=1 from wrapping the timer
                        state_d     = ST_BUS_RESET;
                        bus_reset_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_BUS_RESET: begin
                    if (ls != USB_LS_SE0) begin
                        state_d     = ST_RUN;
                        bus_reset_d = 1'b0;
                        restart_d   = 1'b1;
                        if (count_q != RESET_COUNT_MAX) count_d = count_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bus_reset_q <= 1'b0;
            restart_q   <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bus_reset_q <= bus_reset_d;
            restart_q   <= restart_d;
            count_q     <= count_d;
        end
    end

    assign O_linestate   = ls;
    assign O_bus_reset   = bus_reset_q;
    assign O_restart     = restart_q;
    assign O_reset_count = count_q;

endmodule

// File: tb/tb_usb_linestate_filter.sv
// Bench for usb_linestate_filter: directed scenarios plus random linestate
// runs, checked every cycle against a sliding-window / run-length model.
module tb_usb_linestate_filter;

    localparam int S = 2;
    localparam int D = 4;
    localparam int R = 16;

    logic       fe_clk = 1'b0;
    logic       resetn = 1'b0;
    logic       fe_linestate0 = 1'b0;
    logic       fe_linestate1 = 1'b0;
    logic       I_enable = 1'b0;
    logic [1:0] O_linestate;
    logic       O_changed;
    logic       O_bus_reset;
    logic       O_restart;
    logic [7:0] O_reset_count;

    usb_linestate_filter #(
        .pSYNC_STAGES  (S),
        .pDEBOUNCE     (D),
        .pSE0_RESET    (R),
        .pCOUNTER_WIDTH(21)
    ) dut (
        .fe_clk       (fe_clk),
        .resetn       (resetn),
        .fe_linestate0(fe_linestate0),
        .fe_linestate1(fe_linestate1),
        .I_enable     (I_enable),
        .O_linestate  (O_linestate),
        .O_changed    (O_changed),
        .O_bus_reset  (O_bus_reset),
        .O_restart    (O_restart),
        .O_reset_count(O_reset_count)
    );

    always #5 fe_clk = ~fe_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model. Linestate: the raw value accepted once D consecutive raw
    // samples, taken S edges earlier, agree. Bus reset: en held and linestate SE0
    // for at least R consecutive edges. Restart: bus reset was active and the
    // linestate has left SE0.
    logic [1:0] win[$];
    logic [1:0] ls_m;
    logic       chg_m, br_m, rs_m;
    logic [7:0] cnt_m;
    int         run_m;
    int         edge_n;

    task automatic model_reset();
        win.delete();
        for (int i = 0; i < S + D + 1; i++) win.push_back(2'b00);
        ls_m = 2'b00; chg_m = 1'b0; br_m = 1'b0; rs_m = 1'b0;
        cnt_m = 8'd0; run_m = 0; edge_n = 0;
    endtask

    task automatic step(input logic [1:0] raw, input logic en);
        logic       all_eq;
        logic [1:0] ls_prev;
        logic       br_prev;
        fe_linestate0 = raw[0];
        fe_linestate1 = raw[1];
        I_enable      = en;
        @(posedge fe_clk);
        edge_n++;
        win.push_back(raw);
        void'(win.pop_front());
        all_eq = 1'b1;
        for (int i = 1; i < D; i++) if (win[i] != win[0]) all_eq = 1'b0;
        ls_prev = ls_m;
        br_prev = br_m;
        if (all_eq) ls_m = win[0];
        chg_m = (ls_m != ls_prev);
        br_m  = en && (run_m >= R);
        rs_m  = en && br_prev && (ls_prev != 2'b00);
        if (rs_m && cnt_m != 8'd255) cnt_m = cnt_m + 8'd1;
        run_m = (en && ls_m == 2'b00) ? run_m + 1 : 0;
        #1;
    endtask

    task automatic test_reset();
        int first_j;
        int pulses;
        resetn = 1'b0;
        fe_linestate0 = 1'b1; fe_linestate1 = 1'b0; I_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge fe_clk); #1;
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !== 13'd0) begin
                n_bad++;
                $display("FAIL reset_state cycle %0d: got %h want 0", i,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count});
            end
        end
        resetn = 1'b1;
        model_reset();
        first_j = -1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'b01, 1'b1);
            if (O_linestate == 2'b01 && first_j < 0) first_j = edge_n;
            if (O_changed) pulses++;
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                n_bad++;
                $display("FAIL reset_release edge %0d: got %h want %h", edge_n,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                         {ls_m, chg_m, br_m, rs_m, cnt_m});
            end
        end
        n_cmp++;
        if (first_j !== 7 || pulses !== 1) begin
            n_bad++;
            $display("FAIL release_latency: got edge %0d pulses %0d want edge 7 pulses 1", first_j, pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        logic [1:0] seq[$];
        seq.delete();
        for (int i = 0; i < 3; i++) seq.push_back(2'b10);
        for (int i = 0; i < 12; i++) seq.push_back(2'b01);
        pulses = 0;
        foreach (seq[k]) begin
            step(seq[k], 1'b1);
            if (O_changed) pulses++;
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                n_bad++;
                $display("FAIL glitch edge %0d: got %h want %h", edge_n,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                         {ls_m, chg_m, br_m, rs_m, cnt_m});
            end
        end
        n_cmp++;
        if (pulses !== 0 || O_linestate !== 2'b01) begin
            n_bad++;
            $display("FAIL glitch_filtered: got ls %b pulses %0d want ls 01 pulses 0", O_linestate, pulses);
        end
    endtask

    task automatic test_step();
        int t_k;
        int pulses;
        t_k = -1; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(2'b10, 1'b1);
            if (O_linestate == 2'b10 && t_k < 0) t_k = i;
            if (O_changed) pulses++;
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                n_bad++;
                $display("FAIL step edge %0d: got %h want %h", edge_n,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                         {ls_m, chg_m, br_m, rs_m, cnt_m});
            end
        end
        n_cmp++;
        if (t_k !== 7 || pulses !== 1) begin
            n_bad++;
            $display("FAIL step_latency: got edge %0d pulses %0d want edge 7 pulses 1", t_k, pulses);
        end
    endtask

    // Drives an SE0 pattern then J, measuring bus reset / restart timing.
    task automatic run_se0(input string name, input int se0_len, input int glitch_at,
                           input logic expect_reset);
        int t_se0, t_br, t_j, t_rs, n_rs;
        logic [7:0] cnt0;
        logic [1:0] raw;
        cnt0 = O_reset_count;
        t_se0 = -1; t_br = -1; t_j = -1; t_rs = -1; n_rs = 0;
        for (int i = 1; i <= se0_len + 15; i++) begin
            raw = (i > se0_len) ? 2'b01 : 2'b00;
            if (glitch_at > 0 && (i == glitch_at || i == glitch_at + 1)) raw = 2'b01;
            step(raw, 1'b1);
            if (O_linestate == 2'b00 && t_se0 < 0) t_se0 = i;
            if (O_bus_reset && t_br < 0) t_br = i;
            if (O_linestate == 2'b01 && t_se0 >= 0 && t_j < 0) t_j = i;
            if (O_restart) begin n_rs++; t_rs = i; end
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                n_bad++;
                $display("FAIL %s edge %0d: got %h want %h", name, edge_n,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                         {ls_m, chg_m, br_m, rs_m, cnt_m});
            end
        end
        n_cmp++;
        if (expect_reset) begin
            if (t_br - t_se0 !== R || t_rs - t_j !== 1 || n_rs !== 1 || O_reset_count !== cnt0 + 8'd1) begin
                n_bad++;
                $display("FAIL %s_timing: got br_delay %0d rs_delay %0d pulses %0d count %0d want %0d 1 1 %0d",
                         name, t_br - t_se0, t_rs - t_j, n_rs, O_reset_count, R, cnt0 + 8'd1);
            end
        end else begin
            if (t_br !== -1 || n_rs !== 0 || O_reset_count !== cnt0) begin
                n_bad++;
                $display("FAIL %s_no_reset: got br_edge %0d pulses %0d count %0d want -1 0 %0d",
                         name, t_br, n_rs, O_reset_count, cnt0);
            end
        end
    endtask

    task automatic test_bus_reset();
        run_se0("bus_reset", 30, 0, 1'b1);
    endtask

    task automatic test_short_se0();
        run_se0("short_se0", 10, 0, 1'b0);
        run_se0("se0_glitch", 30, 13, 1'b1);
    endtask

    task automatic test_enable_drop();
        logic [7:0] cnt0;
        int n_rs;
        cnt0 = O_reset_count;
        n_rs = 0;
        for (int i = 0; i < 25; i++) step(2'b00, 1'b1);
        n_cmp++;
        if (O_bus_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL en_drop_pre: got bus_reset %b want 1", O_bus_reset);
        end
        for (int i = 0; i < 14; i++) begin
            step((i == 0) ? 2'b00 : 2'b01, 1'b0);
            if (O_restart) n_rs++;
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                n_bad++;
                $display("FAIL en_drop edge %0d: got %h want %h", edge_n,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                         {ls_m, chg_m, br_m, rs_m, cnt_m});
            end
        end
        n_cmp++;
        if (n_rs !== 0 || O_reset_count !== cnt0 || O_bus_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop_effect: got pulses %0d count %0d br %b want 0 %0d 0",
                     n_rs, O_reset_count, O_bus_reset, cnt0);
        end
        for (int i = 0; i < 3; i++) step(2'b01, 1'b1);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 260; r++) begin
            for (int i = 0; i < 30; i++) begin
                step((i < 20) ? 2'b00 : 2'b01, 1'b1);
                n_cmp++;
                if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                    {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                    n_bad++;
                    $display("FAIL saturation edge %0d: got %h want %h", edge_n,
                             {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                             {ls_m, chg_m, br_m, rs_m, cnt_m});
                end
            end
        end
        n_cmp++;
        if (O_reset_count !== 8'd255) begin
            n_bad++;
            $display("FAIL count_saturate: got %0d want 255", O_reset_count);
        end
    endtask

    task automatic test_random();
        logic [1:0] raw;
        logic en;
        int len;
        for (int seg = 0; seg < 60; seg++) begin
            raw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) raw = 2'b00;
            en  = ($urandom_range(0, 9) != 0);
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                step(raw, en);
                n_cmp++;
                if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                    {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                    n_bad++;
                    $display("FAIL random edge %0d: got %h want %h", edge_n,
                             {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                             {ls_m, chg_m, br_m, rs_m, cnt_m});
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 25; i++) step(2'b00, 1'b1);
        resetn = 1'b0;
        fe_linestate0 = 1'b1; fe_linestate1 = 1'b0;
        @(posedge fe_clk); #1;
        n_cmp++;
        if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !== 13'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %h want 0",
                     {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count});
        end
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(2'b01, 1'b1);
            n_cmp++;
            if ({O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count} !==
                {ls_m, chg_m, br_m, rs_m, cnt_m}) begin
                n_bad++;
                $display("FAIL mid_reset_after edge %0d: got %h want %h", edge_n,
                         {O_linestate, O_changed, O_bus_reset, O_restart, O_reset_count},
                         {ls_m, chg_m, br_m, rs_m, cnt_m});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_step();
        for (int i = 0; i < 10; i++) step(2'b01, 1'b1);
        test_bus_reset();
        test_short_se0();
        test_enable_drop();
        test_random();
        test_mid_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
